// File: rtl/ldpc_bitflip_decode.sv
// ldpc_bitflip_decode
// Hard-decision LDPC bit-flipping decoder. Accepts one N-bit received word
// together with a row-major flattened (N-K)xN parity-check matrix, then
// alternates syndrome evaluation and majority bit flipping until the
// syndrome is zero or MAX_ITER flips have been performed.
//
// Optional build macro: LDPC_BF_STATUS_EN adds o_success / o_iters.
//
// Ports
//   clk            rising-edge clock
//   i_rst          synchronous active-high reset
//   i_valid        input word present (accepted in IDLE)
//   i_codeword     received word, bit c = position c
//   i_parity_check H matrix, H[r][c] = i_parity_check[r*N + c]
//   o_ready        block can accept a word
//   o_valid        one-cycle pulse, o_codeword holds a new result
//   o_codeword     decoded word, held until next result
//   o_success      (status build) final syndrome was zero
//   o_iters        (status build) number of flip iterations performed
module ldpc_bitflip_decode #(
    parameter int unsigned N        = 6,
    parameter int unsigned K        = 3,
    parameter int unsigned MAX_ITER = 8
) (
    input  logic                            clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    input  logic [N-1:0]                    i_codeword,
    input  logic [(N-K)*N-1:0]              i_parity_check,
    output logic                            o_ready,
    output logic                            o_valid,
`ifdef LDPC_BF_STATUS_EN
    output logic                            o_success,
    output logic [$clog2(MAX_ITER+1)-1:0]   o_iters,
`endif
    output logic [N-1:0]                    o_codeword
);

    localparam int unsigned M  = N - K;
    localparam int unsigned HW = M * N;
    localparam int unsigned CW = $clog2(M + 1);
    localparam int unsigned IW = $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYND = 2'd1,
        FLIP = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    w_q, w_d;
    logic [HW-1:0]   h_q, h_d;
    logic [M-1:0]    s_q, s_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic            succ_q, succ_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic [N-1:0]    cw_q, cw_d;
`ifdef LDPC_BF_STATUS_EN
    logic            o_succ_q, o_succ_d;
    logic [IW-1:0]   o_iters_q, o_iters_d;
`endif

    logic [M-1:0]    syn_c;
    logic [CW-1:0]   cnt_c [N];
    logic [CW-1:0]   max_c;
    logic [N-1:0]    flip_c;

    // Syndrome of the working word: one parity per H row
    always_comb begin
        syn_c = '0;
        for (int r = 0; r < int'(M); r++) begin
            syn_c[r] = ^(h_q[r*N +: N] & w_q);
        end
    end

    // Unsatisfied-check count per bit, its maximum, and the flip mask
    // (all bits tied at the maximum flip; nothing flips if the maximum is 0)
    always_comb begin
        max_c  = '0;
        flip_c = '0;
        for (int c = 0; c < int'(N); c++) begin
            cnt_c[c] = '0;
            for (int r = 0; r < int'(M); r++) begin
                cnt_c[c] = cnt_c[c] + CW'(s_q[r] & h_q[r*N + c]);
            end
            if (cnt_c[c] > max_c) begin
                max_c = cnt_c[c];
            end
        end
        for (int c = 0; c < int'(N); c++) begin
            flip_c[c] = (cnt_c[c] == max_c) && (max_c != '0);
        end
    end

    // Next-state and output-register values
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        s_d     = s_q;
        iter_d  = iter_q;
        succ_d  = succ_q;
        valid_d = 1'b0;
        cw_d    = cw_q;
`ifdef LDPC_BF_STATUS_EN
        o_succ_d  = o_succ_q;
        o_iters_d = o_iters_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    w_d     = i_codeword;
                    h_d     = i_parity_check;
                    iter_d  = '0;
                    state_d = SYND;
                end
            end
            SYND: begin
                s_d = syn_c;
                if (syn_c == '0) begin
                    succ_d  = 1'b1;
                    state_d = DONE;
                end else if (iter_q == IW'(MAX_ITER)) begin
                    succ_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = FLIP;
                end
            end
            FLIP: begin
                w_d     = w_q ^ flip_c;
                iter_d  = iter_q + IW'(1);
                state_d = SYND;
            end
            DONE: begin
                cw_d    = w_q;
                valid_d = 1'b1;
`ifdef LDPC_BF_STATUS_EN
                o_succ_d  = succ_q;
                o_iters_d = iter_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Ready stays low through the result cycle, although IDLE already accepts then
        ready_d = (state_d == IDLE) && (state_q != DONE);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            s_q     <= '0;
            iter_q  <= '0;
            succ_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            cw_q    <= '0;
`ifdef LDPC_BF_STATUS_EN
            o_succ_q  <= 1'b0;
            o_iters_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            s_q     <= s_d;
            iter_q  <= iter_d;
            succ_q  <= succ_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            cw_q    <= cw_d;
`ifdef LDPC_BF_STATUS_EN
            o_succ_q  <= o_succ_d;
            o_iters_q <= o_iters_d;
`endif
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_codeword = cw_q;
`ifdef LDPC_BF_STATUS_EN
    assign o_success  = o_succ_q;
    assign o_iters    = o_iters_q;
`endif

endmodule

// File: tb/tb_ldpc_bitflip_decode.sv
// Directed bench for ldpc_bitflip_decode: two instances (MAX_ITER=8 and 1)
// share clock, reset, word and H; each has its own i_valid.
module tb_ldpc_bitflip_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid8, valid1;
    logic [5:0]  codeword;
    logic [17:0] hmat;

    logic        ready8, ov8, ready1, ov1;
    logic [5:0]  ocw8, ocw1;
`ifdef LDPC_BF_STATUS_EN
    logic        succ8, succ1;
    logic [3:0]  iters8;
    logic [0:0]  iters1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ldpc_bitflip_decode #(.N(6), .K(3), .MAX_ITER(8)) u_dut8 (
        .clk            (clk),
        .i_rst          (rst),
        .i_valid        (valid8),
        .i_codeword     (codeword),
        .i_parity_check (hmat),
        .o_ready        (ready8),
        .o_valid        (ov8),
`ifdef LDPC_BF_STATUS_EN
        .o_success      (succ8),
        .o_iters        (iters8),
`endif
        .o_codeword     (ocw8)
    );

    ldpc_bitflip_decode #(.N(6), .K(3), .MAX_ITER(1)) u_dut1 (
        .clk            (clk),
        .i_rst          (rst),
        .i_valid        (valid1),
        .i_codeword     (codeword),
        .i_parity_check (hmat),
        .o_ready        (ready1),
        .o_valid        (ov1),
`ifdef LDPC_BF_STATUS_EN
        .o_success      (succ1),
        .o_iters        (iters1),
`endif
        .o_codeword     (ocw1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word to the selected instance, return latency and result
    task automatic decode(input bit sel, input logic [5:0] word, output int lat,
                          output logic [5:0] cw, output logic succ, output logic [3:0] it);
        @(negedge clk);
        codeword = word;
        if (sel) valid1 = 1'b1; else valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid1 = 1'b0;
        valid8 = 1'b0;
        lat = 0;
        while (!(sel ? ov1 : ov8) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!(sel ? ov1 : ov8)) lat = 99;
        cw = sel ? ocw1 : ocw8;
        check("ready_low_in_valid_cycle", 32'(sel ? ready1 : ready8), 32'd0);
`ifdef LDPC_BF_STATUS_EN
        succ = sel ? succ1 : succ8;
        it   = sel ? 4'(iters1) : iters8;
`else
        succ = 1'b0;
        it   = 4'd0;
`endif
        @(negedge clk);
        check("valid_one_cycle", 32'(sel ? ov1 : ov8), 32'd0);
        check("ready_after_result", 32'(sel ? ready1 : ready8), 32'd1);
        check("codeword_held", 32'(sel ? ocw1 : ocw8), 32'(cw));
    endtask

    task automatic check_status(input string tag, input logic succ, input logic [3:0] it,
                                input logic exp_succ, input logic [3:0] exp_it);
`ifdef LDPC_BF_STATUS_EN
        check({tag, "_success"}, 32'(succ), 32'(exp_succ));
        check({tag, "_iters"},   32'(it),   32'(exp_it));
`endif
    endtask

    int         lat;
    logic [5:0] cw;
    logic       succ;
    logic [3:0] it;
    int         pulses;

    initial begin
        rst      = 1'b1;
        valid8   = 1'b0;
        valid1   = 1'b0;
        codeword = 6'h00;
        hmat     = 18'h264CD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 32'(ready8), 32'd1);
        check("reset_valid", 32'(ov8), 32'd0);
        check("reset_codeword", 32'(ocw8), 32'd0);
`ifdef LDPC_BF_STATUS_EN
        check("reset_success", 32'(succ8), 32'd0);
        check("reset_iters", 32'(iters8), 32'd0);
`endif

        // Clean codeword
        decode(1'b0, 6'h35, lat, cw, succ, it);
        check("clean_latency", 32'(lat), 32'd2);
        check("clean_codeword", 32'(cw), 32'h35);
        check_status("clean", succ, it, 1'b1, 4'd0);

        // Single error on c0
        decode(1'b0, 6'h34, lat, cw, succ, it);
        check("single_latency", 32'(lat), 32'd4);
        check("single_codeword", 32'(cw), 32'h35);
        check_status("single", succ, it, 1'b1, 4'd1);

        // Iteration limit reached with nonzero syndrome (MAX_ITER=1)
        decode(1'b1, 6'h3D, lat, cw, succ, it);
        check("limit_latency", 32'(lat), 32'd4);
        check("limit_codeword", 32'(cw), 32'h30);
        check_status("limit", succ, it, 1'b0, 4'd1);

        // All-zero word with i_valid pulsed while busy
        @(negedge clk);
        codeword = 6'h00;
        valid8   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        codeword = 6'h34;
        pulses   = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) valid8 = 1'b0;
            if (ov8) begin
                pulses++;
                check("zero_latency", 32'(k), 32'd2);
                check("zero_codeword", 32'(ocw8), 32'h00);
`ifdef LDPC_BF_STATUS_EN
                check("zero_success", 32'(succ8), 32'd1);
`endif
            end
            @(negedge clk);
        end
        check("busy_valid_ignored_pulses", 32'(pulses), 32'd1);

        // Reset one cycle after accepting 6'h34
        @(negedge clk);
        codeword = 6'h34;
        valid8   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid8 = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 32'(ready8), 32'd1);
        check("midrst_codeword", 32'(ocw8), 32'd0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (ov8) pulses++;
            @(negedge clk);
        end
        check("midrst_no_valid", 32'(pulses), 32'd0);
        decode(1'b0, 6'h35, lat, cw, succ, it);
        check("postrst_latency", 32'(lat), 32'd2);
        check("postrst_codeword", 32'(cw), 32'h35);

        // Back-to-back: 6'h35 then 6'h34 with i_valid held
        @(negedge clk);
        codeword = 6'h35;
        valid8   = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) codeword = 6'h34;
            if (k == 3) valid8 = 1'b0;
            check($sformatf("b2b_valid_%0d", k), 32'(ov8), 32'((k == 2) || (k == 7)));
            if (k == 2 || k == 7) check($sformatf("b2b_codeword_%0d", k), 32'(ocw8), 32'h35);
            if (k == 2) check("b2b_ready_in_valid", 32'(ready8), 32'd0);
            if (k == 8) check("b2b_ready_end", 32'(ready8), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
